// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the iterative multiply/divide unit.
//   - op encodings (MIPS MULT / MULTU / DIV / DIVU) and the matching enum
//   - controller state enum (IDLE, RUN, FIX, DONE)
//   - small helpers that classify an op code
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [1:0] OP_ENC_MULT  = 2'b00;
  localparam logic [1:0] OP_ENC_MULTU = 2'b01;
  localparam logic [1:0] OP_ENC_DIV   = 2'b10;
  localparam logic [1:0] OP_ENC_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MULT  = OP_ENC_MULT,
    MULTU = OP_ENC_MULTU,
    DIV   = OP_ENC_DIV,
    DIVU  = OP_ENC_DIVU
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  // True for DIV and DIVU.
  function automatic logic op_is_div(input logic [1:0] i_op);
    return (i_op == OP_ENC_DIV) || (i_op == OP_ENC_DIVU);
  endfunction

  // True for the two's-complement flavours (MULT, DIV).
  function automatic logic op_is_signed(input logic [1:0] i_op);
    return (i_op == OP_ENC_MULT) || (i_op == OP_ENC_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// -----------------------------------------------------------------------------
// mdu_iter_step
// One combinational iteration of the multiply/divide datapath.
//
// Ports:
//   i_mode     0 = multiply step, 1 = restoring-divide step
//   i_acc      2*WIDTH accumulator
//                multiply: running product
//                divide  : {partial remainder, remaining dividend/quotient}
//   i_operand  2*WIDTH operand
//                multiply: shifted multiplicand, already gated by the
//                          current multiplier bit (zero when the bit is 0)
//                divide  : divisor in the low WIDTH bits
//   o_acc      next accumulator (divide: quotient LSB left at 0)
//   o_qbit     quotient bit produced by this step (0 in multiply mode)
// -----------------------------------------------------------------------------
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_mode,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [2*WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_qbit
);

  logic [2*WIDTH-1:0] w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;

  // Divide: shift the next dividend bit into the remainder and trial-subtract.
  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the restored/subtracted result fits back into WIDTH.
  always_comb begin
    w_sum    = i_acc + i_operand;
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_operand[WIDTH-1:0]};
    o_qbit   = 1'b0;
    o_acc    = w_sum;
    if (i_mode) begin
      o_qbit = ~w_diff[WIDTH];
      o_acc  = {(o_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) producing the
// architectural HI/LO pair through a start/busy/done handshake.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, accepted only in IDLE or DONE
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend and multiplier/divisor
//   busy         high while iterating (RUN) and while correcting signs (FIX)
//   done         one-cycle pulse; hi/lo hold the new result in that cycle
//   hi, lo       product upper/lower half, or remainder/quotient
//   div_by_zero  sticky until the next accepted start
//
// Build option:
//   MDU_EARLY_TERM_EN  when defined, multiplies leave RUN as soon as the
//                      remaining multiplier bits are zero (at least one
//                      iteration). Results are identical; divide unchanged.
// -----------------------------------------------------------------------------
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

  mdu_state_e          r_state;
  mdu_state_e          w_next_state;

  mdu_op_e             r_op;
  logic                r_neg_lo;
  logic                r_neg_hi;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_opnd;
  logic [WIDTH-1:0]    r_mplier;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_dbz;

  logic                w_accept;
  logic                w_div_zero;
  logic                w_signed_in;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic                w_run_div;
  logic [2*WIDTH-1:0]  w_step_opnd;
  logic [2*WIDTH-1:0]  w_step_acc;
  logic                w_step_qbit;
  logic                w_early;
  logic                w_run_last;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_quot;
  logic [WIDTH-1:0]    w_rem;
  logic [WIDTH-1:0]    w_res_hi;
  logic [WIDTH-1:0]    w_res_lo;

  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_div_zero  = op_is_div(op) && (b == '0);
  assign w_signed_in = op_is_signed(op);

  // Signed ops iterate on magnitudes; |MIN| wraps to MIN, which is still the
  // correct magnitude when read as unsigned.
  assign w_abs_a = (w_signed_in && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (w_signed_in && b[WIDTH-1]) ? -b : b;

  // Multiply adds the left-shifting multiplicand only when the current
  // multiplier bit is set; divide always presents the divisor.
  assign w_run_div   = op_is_div(r_op);
  assign w_step_opnd = (w_run_div || r_mplier[0]) ? r_opnd : '0;

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode    (w_run_div),
    .i_acc     (r_acc),
    .i_operand (w_step_opnd),
    .o_acc     (w_step_acc),
    .o_qbit    (w_step_qbit)
  );

`ifdef MDU_EARLY_TERM_EN
  // Bits above the one consumed this edge are all zero: nothing left to add.
  assign w_early = !w_run_div && (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_run_last = (r_cnt == LAST_ITER) || w_early;

  // Sign correction applied in FIX. The remainder follows the dividend sign.
  assign w_prod   = r_neg_lo ? -r_acc : r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_run_div ? (r_neg_lo ? -w_quot : w_quot) : w_prod[WIDTH-1:0];
  assign w_res_hi = w_run_div ? (r_neg_hi ? -w_rem  : w_rem ) : w_prod[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. A divide by zero skips the iteration entirely.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_next_state = w_div_zero ? DONE : RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN:     w_next_state = w_run_last ? FIX : RUN;
      FIX:     w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      RUN, FIX: busy = 1'b1;
      DONE:     done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath. Operands load on accept; hi/lo only change in FIX or on a
  // divide by zero, so they hold between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MULT;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= mdu_op_e'(op);
      r_neg_lo <= w_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_hi <= w_signed_in && a[WIDTH-1];
      r_cnt    <= '0;
      r_dbz    <= w_div_zero;
      r_mplier <= w_abs_b;
      if (op_is_div(op)) begin
        r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
        r_opnd <= {{WIDTH{1'b0}}, w_abs_b};
      end else begin
        r_acc  <= '0;
        r_opnd <= {{WIDTH{1'b0}}, w_abs_a};
      end
      if (w_div_zero) begin
        r_hi <= a;
        r_lo <= '1;
      end
    end else if (r_state == RUN) begin
      r_acc    <= {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_step_qbit};
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (!w_run_div) begin
        r_opnd <= r_opnd << 1;
      end
    end else if (r_state == FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
